lte_ul_src_sched: RTL and testbench

LTE_UL_SRC_SCHED -- requirements
Module: lte_ul_src_sched

---
 rtl/lte_ul_pkg.sv | 48 ++++
 rtl/lte_ul_sched_cfgbank.sv | 103 ++++++++++
 rtl/lte_ul_src_sched.sv | 175 +++++++++++++++++
 tb/tb_lte_ul_src_sched.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/lte_ul_pkg.sv
// rtl/lte_ul_pkg.sv - shared definitions for the LTE uplink source scheduler
//
// Holds the register address map, the decoded schedule-entry layout, the
// scheduler state encoding and the default frame length in clk cycles.
package lte_ul_pkg;

  // One 10 ms radio frame at the 491.52 MHz sample clock.
  localparam int unsigned FRAME_CYC_10MS = 4915200;

  // Configuration address map (0..7 are schedule entries).
  localparam logic [3:0] ADDR_IQSEL  = 4'd8;
  localparam logic [3:0] ADDR_DSTART = 4'd9;
  localparam logic [3:0] ADDR_DEND   = 4'd10;
  localparam logic [3:0] ADDR_CTRL   = 4'd11;

  // Control register bits.
  localparam int CTRL_EN   = 0;
  localparam int CTRL_LOOP = 1;

  // Entry word bit fields.
  localparam int ENT_VLD_LSB   = 0;
  localparam int ENT_VLD_MSB   = 2;
  localparam int ENT_SEL       = 3;
  localparam int ENT_DWELL_LSB = 4;
  localparam int ENT_DWELL_MSB = 11;
  localparam int ENT_LAST      = 15;

  // Entry as stored: only the meaningful fields of the written word are kept.
  typedef struct packed {
    logic       last;
    logic [7:0] dwell;
    logic       sel;
    logic [2:0] vld;
  } ent_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_HD = 2'd1,
    ST_RUN     = 2'd2,
    ST_DONE    = 2'd3
  } sched_state_t;

  // A dwell of zero frames behaves as one frame.
  function automatic logic [7:0] dwell_load(input logic [7:0] d);
    return (d == 8'd0) ? 8'd1 : d;
  endfunction

endpackage

// File: rtl/lte_ul_sched_cfgbank.sv
// rtl/lte_ul_sched_cfgbank.sv - shadow/active configuration bank with frame-aligned swap
//
// Ports:
//   clk, asy_rst          clock, asynchronous active-low reset
//   framn_hd              frame-head pulse
//   cfg_wr/addr/wdata     shadow register write port
//   cfg_commit            request a shadow->active copy at the next frame head
//   cfg_pend              commit accepted, swap not yet done
//   swap                  combinational: the copy happens at this clock edge
//   sh_ent0, sh_en        shadow entry 0 / enable, i.e. what becomes active on swap
//   act_*                 active (applied) configuration
module lte_ul_sched_cfgbank
  import lte_ul_pkg::*;
#(
  parameter int unsigned N_ENT = 8
) (
  input  logic                   clk,
  input  logic                   asy_rst,
  input  logic                   framn_hd,
  input  logic                   cfg_wr,
  input  logic [3:0]             cfg_addr,
  input  logic [31:0]            cfg_wdata,
  input  logic                   cfg_commit,
  output logic                   cfg_pend,
  output logic                   swap,
  output ent_t                   sh_ent0,
  output logic                   sh_en,
  output ent_t [N_ENT-1:0]       act_ent,
  output logic                   act_en,
  output logic                   act_loop,
  output logic [31:0]            act_iqsel,
  output logic [31:0]            act_start,
  output logic [31:0]            act_end
);

  ent_t [N_ENT-1:0] sh_ent;
  logic [31:0]      sh_iqsel;
  logic [31:0]      sh_start;
  logic [31:0]      sh_end;
  logic [1:0]       sh_ctrl;
  logic [1:0]       act_ctrl;

  assign swap     = framn_hd & cfg_pend;
  assign sh_ent0  = sh_ent[0];
  assign sh_en    = sh_ctrl[CTRL_EN];
  assign act_en   = act_ctrl[CTRL_EN];
  assign act_loop = act_ctrl[CTRL_LOOP];

  // Shadow set: written immediately; addresses 12..15 and entries beyond
  // N_ENT fall through without effect.
  always_ff @(posedge clk or negedge asy_rst) begin
    if (!asy_rst) begin
      sh_ent   <= '0;
      sh_iqsel <= '0;
      sh_start <= '0;
      sh_end   <= '0;
      sh_ctrl  <= '0;
    end else if (cfg_wr) begin
      for (int i = 0; i < int'(N_ENT); i++) begin
        if (cfg_addr == 4'(i)) begin
          sh_ent[i] <= '{last:  cfg_wdata[ENT_LAST],
                         dwell: cfg_wdata[ENT_DWELL_MSB:ENT_DWELL_LSB],
                         sel:   cfg_wdata[ENT_SEL],
                         vld:   cfg_wdata[ENT_VLD_MSB:ENT_VLD_LSB]};
        end
      end
      case (cfg_addr)
        ADDR_IQSEL:  sh_iqsel <= cfg_wdata;
        ADDR_DSTART: sh_start <= cfg_wdata;
        ADDR_DEND:   sh_end   <= cfg_wdata;
        ADDR_CTRL:   sh_ctrl  <= cfg_wdata[1:0];
        default:     ;
      endcase
    end
  end

  // Active set and pending flag. The copy takes the pre-edge shadow values,
  // so a write landing in the swap cycle only reaches the shadow.
  always_ff @(posedge clk or negedge asy_rst) begin
    if (!asy_rst) begin
      cfg_pend  <= 1'b0;
      act_ent   <= '0;
      act_iqsel <= '0;
      act_start <= '0;
      act_end   <= '0;
      act_ctrl  <= '0;
    end else begin
      if (swap) begin
        cfg_pend  <= 1'b0;
        act_ent   <= sh_ent;
        act_iqsel <= sh_iqsel;
        act_start <= sh_start;
        act_end   <= sh_end;
        act_ctrl  <= sh_ctrl;
      end else if (cfg_commit) begin
        // Re-committing while pending is a no-op; a commit alongside a head
        // with nothing pending arms the swap for the following head.
        cfg_pend <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/lte_ul_src_sched.sv
// rtl/lte_ul_src_sched.sv - frame-driven uplink source test-mode scheduler
//
// Steps through a table of entries, each holding a test code for a number of
// frames, with a head-of-frame watchdog.
//
// Ports:
//   clk, asy_rst          clock, asynchronous active-low reset
//   i_framn_hd            frame-head pulse (one cycle)
//   i_cfg_wr/addr/wdata   shadow register write port
//   i_cfg_commit          apply shadow registers at next frame head
//   o_cfg_pend            commit pending
//   o_test_sel/o_test_vld test path select / test-mode code
//   o_cell_iqselcfg       active IQ-select configuration
//   o_data_start/end      active window bounds
//   o_entry_idx           active entry index
//   o_done                non-looping schedule finished
//   o_hd_miss             sticky missed-frame-head flag
module lte_ul_src_sched
  import lte_ul_pkg::*;
#(
  parameter int unsigned FRAME_CYC = FRAME_CYC_10MS,
  parameter int unsigned N_ENT     = 8
) (
  input  logic        clk,
  input  logic        asy_rst,
  input  logic        i_framn_hd,
  input  logic        i_cfg_wr,
  input  logic [3:0]  i_cfg_addr,
  input  logic [31:0] i_cfg_wdata,
  input  logic        i_cfg_commit,
  output logic        o_cfg_pend,
  output logic        o_test_sel,
  output logic [2:0]  o_test_vld,
  output logic [31:0] o_cell_iqselcfg,
  output logic [31:0] o_data_start,
  output logic [31:0] o_data_end,
  output logic [2:0]  o_entry_idx,
  output logic        o_done,
  output logic        o_hd_miss
);

  // The watchdog trips on the step that would bring the counter to
  // FRAME_CYC+16, i.e. exactly FRAME_CYC+16 cycles after the last head.
  localparam logic [23:0] WD_LAST = 24'(FRAME_CYC + 15);
  localparam logic [2:0]  IDX_MAX = 3'(N_ENT - 1);

  logic             swap;
  logic             sh_en;
  logic             act_en;
  logic             act_loop;
  ent_t             sh_ent0;
  ent_t [N_ENT-1:0] act_ent;

  sched_state_t     state;
  logic [7:0]       dwell_cnt;
  logic             cur_last;
  logic [23:0]      wd_cnt;
  logic             wd_expire;
  logic             adv_wrap;
  logic [2:0]       adv_idx;
  ent_t             adv_ent;

  lte_ul_sched_cfgbank #(
    .N_ENT (N_ENT)
  ) u_cfgbank (
    .clk        (clk),
    .asy_rst    (asy_rst),
    .framn_hd   (i_framn_hd),
    .cfg_wr     (i_cfg_wr),
    .cfg_addr   (i_cfg_addr),
    .cfg_wdata  (i_cfg_wdata),
    .cfg_commit (i_cfg_commit),
    .cfg_pend   (o_cfg_pend),
    .swap       (swap),
    .sh_ent0    (sh_ent0),
    .sh_en      (sh_en),
    .act_ent    (act_ent),
    .act_en     (act_en),
    .act_loop   (act_loop),
    .act_iqsel  (o_cell_iqselcfg),
    .act_start  (o_data_start),
    .act_end    (o_data_end)
  );

  // Next entry on advance: wrap after a flagged last entry or the table end.
  always_comb begin
    adv_wrap = cur_last || (o_entry_idx == IDX_MAX);
    adv_idx  = adv_wrap ? 3'd0 : (o_entry_idx + 3'd1);
    adv_ent  = act_ent[adv_idx];
  end

  assign wd_expire = ((state == ST_RUN) || (state == ST_WAIT_HD)) &&
                     !i_framn_hd && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or negedge asy_rst) begin
    if (!asy_rst) begin
      state       <= ST_IDLE;
      o_entry_idx <= '0;
      o_test_sel  <= 1'b0;
      o_test_vld  <= '0;
      o_done      <= 1'b0;
      o_hd_miss   <= 1'b0;
      dwell_cnt   <= '0;
      cur_last    <= 1'b0;
      wd_cnt      <= '0;
    end else begin
      if (i_framn_hd || wd_expire) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + 24'd1;
      end
      if (wd_expire) begin
        o_hd_miss <= 1'b1;
      end

      if (swap) begin
        // A swap overrides whatever the current state would do this head.
        o_hd_miss   <= 1'b0;
        o_done      <= 1'b0;
        o_entry_idx <= 3'd0;
        if (sh_en) begin
          state      <= ST_RUN;
          o_test_sel <= sh_ent0.sel;
          o_test_vld <= sh_ent0.vld;
          dwell_cnt  <= dwell_load(sh_ent0.dwell);
          cur_last   <= sh_ent0.last;
        end else begin
          state      <= ST_IDLE;
          o_test_sel <= 1'b0;
          o_test_vld <= '0;
          dwell_cnt  <= '0;
          cur_last   <= 1'b0;
        end
      end else begin
        case (state)
          ST_IDLE: ;
          ST_WAIT_HD: begin
            if (i_framn_hd) begin
              if (act_en) begin
                state       <= ST_RUN;
                o_entry_idx <= 3'd0;
                o_test_sel  <= act_ent[0].sel;
                o_test_vld  <= act_ent[0].vld;
                dwell_cnt   <= dwell_load(act_ent[0].dwell);
                cur_last    <= act_ent[0].last;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
          ST_RUN: begin
            if (i_framn_hd) begin
              if (dwell_cnt > 8'd1) begin
                dwell_cnt <= dwell_cnt - 8'd1;
              end else if (adv_wrap && !act_loop) begin
                // Outputs of the final entry are left in place.
                state  <= ST_DONE;
                o_done <= 1'b1;
              end else begin
                o_entry_idx <= adv_idx;
                o_test_sel  <= adv_ent.sel;
                o_test_vld  <= adv_ent.vld;
                dwell_cnt   <= dwell_load(adv_ent.dwell);
                cur_last    <= adv_ent.last;
              end
            end
          end
          ST_DONE: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lte_ul_src_sched.sv
// tb/tb_lte_ul_src_sched.sv - directed self-checking bench for lte_ul_src_sched
module tb_lte_ul_src_sched;

  localparam int unsigned FC = 100;

  logic        clk = 1'b0;
  logic        asy_rst = 1'b0;
  logic        i_framn_hd = 1'b0;
  logic        i_cfg_wr = 1'b0;
  logic [3:0]  i_cfg_addr = '0;
  logic [31:0] i_cfg_wdata = '0;
  logic        i_cfg_commit = 1'b0;
  logic        o_cfg_pend;
  logic        o_test_sel;
  logic [2:0]  o_test_vld;
  logic [31:0] o_cell_iqselcfg;
  logic [31:0] o_data_start;
  logic [31:0] o_data_end;
  logic [2:0]  o_entry_idx;
  logic        o_done;
  logic        o_hd_miss;

  int n_cmp = 0;
  int n_bad = 0;

  lte_ul_src_sched #(
    .FRAME_CYC (FC),
    .N_ENT     (8)
  ) dut (
    .clk             (clk),
    .asy_rst         (asy_rst),
    .i_framn_hd      (i_framn_hd),
    .i_cfg_wr        (i_cfg_wr),
    .i_cfg_addr      (i_cfg_addr),
    .i_cfg_wdata     (i_cfg_wdata),
    .i_cfg_commit    (i_cfg_commit),
    .o_cfg_pend      (o_cfg_pend),
    .o_test_sel      (o_test_sel),
    .o_test_vld      (o_test_vld),
    .o_cell_iqselcfg (o_cell_iqselcfg),
    .o_data_start    (o_data_start),
    .o_data_end      (o_data_end),
    .o_entry_idx     (o_entry_idx),
    .o_done          (o_done),
    .o_hd_miss       (o_hd_miss)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    i_cfg_wr = 1'b1; i_cfg_addr = a; i_cfg_wdata = d;
    @(negedge clk);
    i_cfg_wr = 1'b0;
  endtask

  task automatic commit();
    @(negedge clk); i_cfg_commit = 1'b1;
    @(negedge clk); i_cfg_commit = 1'b0;
  endtask

  task automatic head();
    @(negedge clk); i_framn_hd = 1'b1;
    @(negedge clk); i_framn_hd = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_sched(input string tag, input logic [2:0] idx, input logic sel,
                             input logic [2:0] vld, input logic done);
    check_eq({tag, ".idx"},  32'(o_entry_idx), 32'(idx));
    check_eq({tag, ".sel"},  32'(o_test_sel),  32'(sel));
    check_eq({tag, ".vld"},  32'(o_test_vld),  32'(vld));
    check_eq({tag, ".done"}, 32'(o_done),      32'(done));
  endtask

  task automatic check_all_zero(input string tag);
    check_sched(tag, 3'd0, 1'b0, 3'd0, 1'b0);
    check_eq({tag, ".pend"},  32'(o_cfg_pend), 32'd0);
    check_eq({tag, ".miss"},  32'(o_hd_miss),  32'd0);
    check_eq({tag, ".iq"},    o_cell_iqselcfg, 32'd0);
    check_eq({tag, ".start"}, o_data_start,    32'd0);
    check_eq({tag, ".end"},   o_data_end,      32'd0);
  endtask

  // Scenario 2 looping index sequence, one entry per head.
  logic [2:0] loop_idx [6] = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd1};
  logic [2:0] loop_vld [6] = '{3'd1, 3'd1, 3'd2, 3'd1, 3'd1, 3'd2};

  initial begin
    // Reset state
    gap(3);
    check_all_zero("rst");
    @(negedge clk); asy_rst = 1'b1;
    gap(2);

    // Scenario 1: two-entry table, no loop
    cfg_write(4'd0,  32'h0000_0021);
    cfg_write(4'd1,  32'h0000_8012);
    cfg_write(4'd8,  32'hA5A5_0001);
    cfg_write(4'd9,  32'd100);
    cfg_write(4'd10, 32'd200);
    cfg_write(4'd11, 32'd1);
    cfg_write(4'd14, 32'hFFFF_FFFF);   // unmapped, must not hit data_end
    cfg_write(4'd15, 32'd0);           // unmapped, must not clear control
    check_eq("s1.iq_pre", o_cell_iqselcfg, 32'd0);
    commit();
    check_eq("s1.pend", 32'(o_cfg_pend), 32'd1);
    head();
    check_eq("s1.pend_clr", 32'(o_cfg_pend), 32'd0);
    check_eq("s1.iq", o_cell_iqselcfg, 32'hA5A5_0001);
    check_eq("s1.start", o_data_start, 32'd100);
    check_eq("s1.end", o_data_end, 32'd200);
    check_sched("s1.h1", 3'd0, 1'b0, 3'd1, 1'b0);
    gap(8); head();
    check_sched("s1.h2", 3'd0, 1'b0, 3'd1, 1'b0);
    gap(8); head();
    check_sched("s1.h3", 3'd1, 1'b0, 3'd2, 1'b0);
    gap(8); head();
    check_sched("s1.h4", 3'd1, 1'b0, 3'd2, 1'b1);
    gap(8); head();
    check_sched("s1.h5", 3'd1, 1'b0, 3'd2, 1'b1);

    // Scenario 2: same table, looping
    cfg_write(4'd11, 32'd3);
    commit();
    for (int i = 0; i < 6; i++) begin
      gap(8); head();
      check_sched($sformatf("s2.h%0d", i + 1), loop_idx[i], 1'b0, loop_vld[i], 1'b0);
    end

    // Scenario 3: double commit, write in swap cycle, swap beats advance
    gap(8); head();
    gap(8); head();
    check_sched("s3.pre", 3'd0, 1'b0, 3'd1, 1'b0);
    commit();
    commit();
    check_eq("s3.pend", 32'(o_cfg_pend), 32'd1);
    @(negedge clk);
    i_framn_hd = 1'b1; i_cfg_wr = 1'b1; i_cfg_addr = 4'd8; i_cfg_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    i_framn_hd = 1'b0; i_cfg_wr = 1'b0;
    check_eq("s3.pend_clr", 32'(o_cfg_pend), 32'd0);
    check_eq("s3.iq", o_cell_iqselcfg, 32'hA5A5_0001);
    check_sched("s3.restart", 3'd0, 1'b0, 3'd1, 1'b0);
    gap(8); head();
    check_eq("s3.iq_once", o_cell_iqselcfg, 32'hA5A5_0001);
    check_eq("s3.pend_once", 32'(o_cfg_pend), 32'd0);

    // Scenario 4: head watchdog in RUN
    gap(int'(FC) + 15);
    check_eq("s4.miss_early", 32'(o_hd_miss), 32'd0);
    gap(1);
    check_eq("s4.miss_set", 32'(o_hd_miss), 32'd1);
    gap(30);
    check_eq("s4.miss_sticky", 32'(o_hd_miss), 32'd1);
    @(negedge clk); i_cfg_commit = 1'b1; i_framn_hd = 1'b1;
    @(negedge clk); i_cfg_commit = 1'b0; i_framn_hd = 1'b0;
    check_eq("s4.pend_same_cyc", 32'(o_cfg_pend), 32'd1);
    check_eq("s4.miss_no_swap", 32'(o_hd_miss), 32'd1);
    check_eq("s4.iq_no_swap", o_cell_iqselcfg, 32'hA5A5_0001);
    gap(8); head();
    check_eq("s4.miss_clr", 32'(o_hd_miss), 32'd0);
    check_eq("s4.pend_clr", 32'(o_cfg_pend), 32'd0);
    check_eq("s4.iq_new", o_cell_iqselcfg, 32'hDEAD_BEEF);
    check_sched("s4.restart", 3'd0, 1'b0, 3'd1, 1'b0);

    // Scenario 5: reset during entry 1
    gap(8); head();
    gap(8); head();
    check_sched("s5.pre", 3'd1, 1'b0, 3'd2, 1'b0);
    @(negedge clk); asy_rst = 1'b0;
    #1;
    check_all_zero("s5.rst");
    gap(3);
    @(negedge clk); asy_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      gap(8); head();
      check_all_zero($sformatf("s5.idle%0d", i));
    end

    // Recovery with zero dwell entries and test_sel set
    cfg_write(4'd0,  32'h0000_000D);
    cfg_write(4'd1,  32'h0000_8006);
    cfg_write(4'd11, 32'd1);
    commit();
    head();
    check_sched("s5.r1", 3'd0, 1'b1, 3'd5, 1'b0);
    gap(8); head();
    check_sched("s5.r2", 3'd1, 1'b0, 3'd6, 1'b0);
    gap(8); head();
    check_sched("s5.r3", 3'd1, 1'b0, 3'd6, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
